// File: rtl/line_clear_ctrl.sv
// line_clear_ctrl: removes full rows from the playfield grid after a piece
// locks. It scans rows bottom-up and copies every surviving row down to the
// next free destination row. The rows left over at the top are then zeroed.
// Grid access is gated by draw_finish, so storage is never touched while a
// frame is being drawn.
//
// Optional build macro: LINE_CLEAR_TOTAL_EN adds a saturating 16-bit running
// total of cleared lines on output total_lines.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; outputs quiet
// READ  | issue row read of src (only while draw_finish=1)
// WAIT  | storage returns the row; capture it
// EVAL  | full row: count it; else copy it to dst (needs draw_finish=1)
// FILL  | zero rows dst..0 vacated by the compaction
// DONE  | one-cycle done pulse, publish lines_cleared
module line_clear_ctrl #(
    parameter int ROWS = 12,
    parameter int COLS = 12
) (
    input  logic            vga_clk,
    input  logic            rst,
    input  logic            start,
    input  logic            draw_finish,
    output logic            busy,
    output logic            done,
    output logic [3:0]      lines_cleared,
    output logic            rd_en,
    output logic [3:0]      rd_row,
    input  logic [COLS-1:0] rd_data,
    output logic            wr_en,
    output logic [3:0]      wr_row,
    output logic [COLS-1:0] wr_data
`ifdef LINE_CLEAR_TOTAL_EN
    ,
    output logic [15:0]     total_lines
`endif
);

    localparam logic [3:0] LAST_ROW = 4'(ROWS - 1);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        EVAL,
        FILL,
        DONE
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [3:0]      src;
    logic [3:0]      dst;
    logic [3:0]      count;
    logic [COLS-1:0] row;
    logic            row_full;
    logic            eval_go;

    assign row_full = &row;
    // A full row needs no storage access, so it never waits for draw_finish.
    assign eval_go  = (state == EVAL) && (row_full || draw_finish);

    // State register.
    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode and storage port drive; ports idle at zero.
    always_comb begin
        state_next = state;
        busy       = (state != IDLE);
        done       = 1'b0;
        rd_en      = 1'b0;
        rd_row     = 4'd0;
        wr_en      = 1'b0;
        wr_row     = 4'd0;
        wr_data    = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = READ;
                end
            end
            READ: begin
                if (draw_finish) begin
                    rd_en      = 1'b1;
                    rd_row     = src;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                state_next = EVAL;
            end
            EVAL: begin
                if (eval_go) begin
                    if (!row_full) begin
                        wr_en   = 1'b1;
                        wr_row  = dst;
                        wr_data = row;
                    end
                    if (src != 4'd0) begin
                        state_next = READ;
                    end else if (row_full || (count != 4'd0)) begin
                        state_next = FILL;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            FILL: begin
                if (draw_finish) begin
                    wr_en  = 1'b1;
                    wr_row = dst;
                    if (dst == 4'd0) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Scan pointers, captured row, line count and published result.
    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            src           <= 4'd0;
            dst           <= 4'd0;
            count         <= 4'd0;
            row           <= '0;
            lines_cleared <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        src           <= LAST_ROW;
                        dst           <= LAST_ROW;
                        count         <= 4'd0;
                        lines_cleared <= 4'd0;
                    end
                end
                WAIT: begin
                    row <= rd_data;
                end
                EVAL: begin
                    if (eval_go) begin
                        if (row_full) begin
                            count <= count + 4'd1;
                        end else begin
                            dst <= dst - 4'd1;
                        end
                        if (src != 4'd0) begin
                            src <= src - 4'd1;
                        end
                    end
                end
                FILL: begin
                    if (draw_finish && (dst != 4'd0)) begin
                        dst <= dst - 4'd1;
                    end
                end
                DONE: begin
                    lines_cleared <= count;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef LINE_CLEAR_TOTAL_EN
    logic [16:0] total_sum;

    assign total_sum = {1'b0, total_lines} + {13'd0, count};

    // Running total of cleared lines, pinned at all-ones once it overflows.
    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            total_lines <= 16'd0;
        end else if (state == DONE) begin
            total_lines <= total_sum[16] ? 16'hFFFF : total_sum[15:0];
        end
    end
`endif

endmodule

// File: tb/tb_line_clear_ctrl.sv
// Directed bench for line_clear_ctrl with a behavioural row storage model.
module tb_line_clear_ctrl;

    logic        vga_clk = 1'b0;
    logic        rst;
    logic        start;
    logic        draw_finish;
    logic        busy;
    logic        done;
    logic [3:0]  lines_cleared;
    logic        rd_en;
    logic [3:0]  rd_row;
    logic [11:0] rd_data;
    logic        wr_en;
    logic [3:0]  wr_row;
    logic [11:0] wr_data;
`ifdef LINE_CLEAR_TOTAL_EN
    logic [15:0] total_lines;
`endif

    line_clear_ctrl #(.ROWS(12), .COLS(12)) dut (
        .vga_clk       (vga_clk),
        .rst           (rst),
        .start         (start),
        .draw_finish   (draw_finish),
        .busy          (busy),
        .done          (done),
        .lines_cleared (lines_cleared),
        .rd_en         (rd_en),
        .rd_row        (rd_row),
        .rd_data       (rd_data),
        .wr_en         (wr_en),
        .wr_row        (wr_row),
        .wr_data       (wr_data)
`ifdef LINE_CLEAR_TOTAL_EN
        ,
        .total_lines   (total_lines)
`endif
    );

    always #5 vga_clk = ~vga_clk;

    int checks = 0;
    int errors = 0;

    logic [11:0] grid [0:15];
    logic [11:0] img  [0:15];
    logic [11:0] expg [0:15];
    logic        load_req = 1'b0;

    // Row storage: synchronous write, read data one cycle after rd_en.
    always @(posedge vga_clk) begin
        if (load_req) begin
            for (int i = 0; i < 16; i++) grid[i] <= img[i];
        end else if (wr_en) begin
            grid[wr_row] <= wr_data;
        end
        if (rd_en) rd_data <= grid[rd_row];
    end

    int both_cnt = 0;
    always @(negedge vga_clk) begin
        if (rd_en && wr_en) both_cnt++;
    end

    int done_cyc;
    int wr_cnt;
    int hold_viol;
    int done_pulses;
    logic busy_after;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_grid(input string name);
        for (int i = 0; i < 12; i++) begin
            check($sformatf("%s_row%0d", name, i), 32'(grid[i]), 32'(expg[i]));
        end
    endtask

    task automatic load_grid();
        load_req = 1'b1;
        @(negedge vga_clk);
        load_req = 1'b0;
        @(negedge vga_clk);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_busy"},    32'(busy),          32'd0);
        check({name, "_done"},    32'(done),          32'd0);
        check({name, "_rd_en"},   32'(rd_en),         32'd0);
        check({name, "_wr_en"},   32'(wr_en),         32'd0);
        check({name, "_lines"},   32'(lines_cleared), 32'd0);
        check({name, "_rd_row"},  32'(rd_row),        32'd0);
        check({name, "_wr_row"},  32'(wr_row),        32'd0);
        check({name, "_wr_data"}, 32'(wr_data),       32'd0);
`ifdef LINE_CLEAR_TOTAL_EN
        check({name, "_total"},   32'(total_lines),   32'd0);
`endif
    endtask

    // Cycle 0 is the cycle start is high; cycle n is n clocks later.
    task automatic run_pass(input int hold_at, input int hold_len,
                            input int restart_at, input int rst_at);
        done_cyc    = -1;
        wr_cnt      = 0;
        hold_viol   = 0;
        done_pulses = 0;
        busy_after  = 1'b1;
        start       = 1'b1;
        draw_finish = 1'b1;
        #1;
        if (wr_en) wr_cnt++;
        @(negedge vga_clk);
        start = 1'b0;
        for (int cyc = 1; cyc < 200; cyc++) begin
            draw_finish = !(cyc >= hold_at && cyc < hold_at + hold_len);
            start       = (cyc == restart_at);
            if (cyc == rst_at) begin
                rst         = 1'b1;
                start       = 1'b0;
                draw_finish = 1'b1;
                break;
            end
            #1;
            if (wr_en) wr_cnt++;
            if (!draw_finish && (rd_en || wr_en)) hold_viol++;
            if (done) begin
                done_pulses++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_cyc >= 0 && cyc == done_cyc + 1) busy_after = busy;
            if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
            @(negedge vga_clk);
        end
        start       = 1'b0;
        draw_finish = 1'b1;
    endtask

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        draw_finish = 1'b1;
        for (int i = 0; i < 16; i++) img[i] = 12'h000;
        repeat (3) @(negedge vga_clk);
        #1;
        check_reset_outputs("reset");
        @(negedge vga_clk);
        rst = 1'b0;
        @(negedge vga_clk);

        // No full rows: grid unchanged, done at cycle 37.
        for (int i = 0; i < 12; i++) img[i] = 12'h100 + 12'(i);
        for (int i = 0; i < 12; i++) expg[i] = 12'h100 + 12'(i);
        load_grid();
        run_pass(1000, 0, -1, -1);
        check("nofull_done_cyc", 32'(done_cyc), 32'd37);
        check("nofull_pulses", 32'(done_pulses), 32'd1);
        check("nofull_busy_after", 32'(busy_after), 32'd0);
        check("nofull_lines", 32'(lines_cleared), 32'd0);
        check("nofull_writes", 32'(wr_cnt), 32'd12);
        check_grid("nofull");
        @(negedge vga_clk);

        // Bottom row full, the rest 001: shift down by one.
        for (int i = 0; i < 12; i++) img[i] = 12'h001;
        img[11] = 12'hFFF;
        for (int i = 1; i < 12; i++) expg[i] = 12'h001;
        expg[0] = 12'h000;
        load_grid();
        run_pass(1000, 0, -1, -1);
        check("one_done_cyc", 32'(done_cyc), 32'd38);
        check("one_pulses", 32'(done_pulses), 32'd1);
        check("one_lines", 32'(lines_cleared), 32'd1);
        check("one_writes", 32'(wr_cnt), 32'd12);
        check_grid("one");
        @(negedge vga_clk);

        // Rows 11, 9, 8 full; a stray start at cycle 5 must be ignored.
        for (int i = 0; i < 8; i++) img[i] = 12'h010 + 12'(i);
        img[8]  = 12'hFFF;
        img[9]  = 12'hFFF;
        img[10] = 12'h01A;
        img[11] = 12'hFFF;
        for (int k = 0; k < 8; k++) expg[3 + k] = 12'h010 + 12'(k);
        expg[11] = 12'h01A;
        expg[0]  = 12'h000;
        expg[1]  = 12'h000;
        expg[2]  = 12'h000;
        load_grid();
        run_pass(1000, 0, 5, -1);
        check("three_done_cyc", 32'(done_cyc), 32'd40);
        check("three_pulses", 32'(done_pulses), 32'd1);
        check("three_lines", 32'(lines_cleared), 32'd3);
        check_grid("three");
        @(negedge vga_clk);

        // Same grid with draw_finish low for cycles 10..29 (a READ stall).
        load_grid();
        run_pass(10, 20, -1, -1);
        check("hold_done_cyc", 32'(done_cyc), 32'd60);
        check("hold_port_activity", 32'(hold_viol), 32'd0);
        check("hold_lines", 32'(lines_cleared), 32'd3);
        check_grid("hold");
        @(negedge vga_clk);

        // All rows full: only FILL writes, everything zeroed.
        for (int i = 0; i < 12; i++) img[i] = 12'hFFF;
        for (int i = 0; i < 12; i++) expg[i] = 12'h000;
        load_grid();
        run_pass(1000, 0, -1, -1);
        check("full_done_cyc", 32'(done_cyc), 32'd49);
        check("full_writes", 32'(wr_cnt), 32'd12);
        check("full_lines", 32'(lines_cleared), 32'd12);
        check_grid("full");
`ifdef LINE_CLEAR_TOTAL_EN
        check("full_total", 32'(total_lines), 32'd19);
`endif
        @(negedge vga_clk);

        // Reset at cycle 40, during FILL after rows 11, 10, 9 were zeroed.
        load_grid();
        run_pass(1000, 0, -1, 40);
        #1;
        check("rstfill_writes_before", 32'(wr_cnt), 32'd3);
        check_reset_outputs("rstfill");
        @(negedge vga_clk);
        rst = 1'b0;
        repeat (3) @(negedge vga_clk);
        check("rstfill_row10", 32'(grid[10]), 32'h000);
        check("rstfill_row9", 32'(grid[9]), 32'h000);
        check("rstfill_row8", 32'(grid[8]), 32'hFFF);
        check("rstfill_row0", 32'(grid[0]), 32'hFFF);

        // Fresh pass after the reset with a full bottom row.
        for (int i = 0; i < 12; i++) img[i] = 12'h001;
        img[11] = 12'hFFF;
        for (int i = 1; i < 12; i++) expg[i] = 12'h001;
        expg[0] = 12'h000;
        load_grid();
        run_pass(1000, 0, -1, -1);
        check("after_rst_done_cyc", 32'(done_cyc), 32'd38);
        check("after_rst_lines", 32'(lines_cleared), 32'd1);
        check_grid("after_rst");
`ifdef LINE_CLEAR_TOTAL_EN
        check("after_rst_total", 32'(total_lines), 32'd1);
`endif
        @(negedge vga_clk);

        check("rd_wr_overlap", 32'(both_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
